hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 15 +
 rtl/hazard_ctrl_mc_seq.sv | 69 ++++++
 rtl/hazard_ctrl.sv | 116 +++++++++++
 tb/tb_hazard_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared defines for the hazard controller
// Multi-cycle sequencer state encoding and redirect constants.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'd0,
    MC_START = 2'd1,
    MC_WAIT  = 2'd2,
    MC_DONE  = 2'd3
  } mc_state_e;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;
  localparam logic [31:0] ERET_CODE_DEFAULT  = 32'h0000000e;

endpackage

// File: rtl/hazard_ctrl_mc_seq.sv
// rtl/hazard_ctrl_mc_seq.sv - per-unit multi-cycle EX sequencer
// Issues one start pulse, waits for ready, then releases the stall for exactly one cycle.
module mc_seq
  import hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic ready_i,
  input  logic hold_i,
  input  logic exc_i,
  output logic start_o,
  output logic abort_o,
  output logic stall_o
);

  mc_state_e state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MC_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_o = 1'b0;
    abort_o = 1'b0;
    stall_o = 1'b0;
    case (state_q)
      MC_IDLE: begin
        stall_o = req_i;
        if (req_i && !hold_i && !exc_i) begin
          state_d = MC_START;
        end
      end
      MC_START: begin
        stall_o = 1'b1;
        if (exc_i) begin
          abort_o = 1'b1;
          state_d = MC_IDLE;
        end else begin
          start_o = 1'b1;
          state_d = MC_WAIT;
        end
      end
      MC_WAIT: begin
        stall_o = 1'b1;
        if (exc_i) begin
          abort_o = 1'b1;
          state_d = MC_IDLE;
        end else if (ready_i) begin
          state_d = MC_DONE;
        end
      end
      MC_DONE: begin
        // Stall released here so the instruction leaves EX exactly once.
        abort_o = exc_i;
        state_d = MC_IDLE;
      end
      default: begin
        state_d = MC_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/redirect controller
// Combines load-use, branch and multi-cycle stalls with exception flush and deferred redirect.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int          NUM_MC     = 2,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
  parameter logic [31:0] ERET_CODE  = ERET_CODE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        ex_rt,
  input  logic              ex_rmem,
  input  logic              id_j_b_stall,
  input  logic              stallreq_from_if,
  input  logic              stallreq_from_mem,
  input  logic [NUM_MC-1:0] mc_req,
  input  logic [NUM_MC-1:0] mc_ready,
  output logic [NUM_MC-1:0] mc_start,
  output logic [NUM_MC-1:0] mc_abort,
  input  logic [31:0]       mem_excepttype,
  input  logic [31:0]       mem_cp0_epc,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              wb_stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              mem_flush,
  output logic              wb_flush,
  output logic [31:0]       mem_newpc,
  output logic              redirect_valid
);

  logic              lwstall;
  logic              exc;
  logic              mc_stall;
  logic [NUM_MC-1:0] unit_stall;
  logic [31:0]       exc_pc;
  logic              flush_all;
  logic              pend_q, pend_d;
  logic [31:0]       pend_pc_q, pend_pc_d;

  assign lwstall = ex_rmem && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign exc     = (mem_excepttype != 32'd0);

  for (genvar k = 0; k < NUM_MC; k++) begin : g_mc
    mc_seq u_mc_seq (
      .clk     (clk),
      .rst     (rst),
      .req_i   (mc_req[k]),
      .ready_i (mc_ready[k]),
      .hold_i  (stallreq_from_mem),
      .exc_i   (exc),
      .start_o (mc_start[k]),
      .abort_o (mc_abort[k]),
      .stall_o (unit_stall[k])
    );
  end

  // A pending request in IDLE must not hold the pipeline while reset is applied.
  assign mc_stall = (|unit_stall) && !rst;

  assign if_stall  = lwstall || id_j_b_stall || mc_stall || stallreq_from_if || stallreq_from_mem;
  assign id_stall  = if_stall;
  assign ex_stall  = mc_stall || stallreq_from_mem;
  assign mem_stall = ex_stall;
  assign wb_stall  = ex_stall;

  assign flush_all = exc || pend_q;
  assign if_flush  = flush_all;
  assign id_flush  = flush_all;
  assign mem_flush = flush_all;
  assign wb_flush  = flush_all;
  assign ex_flush  = flush_all || ((lwstall || id_j_b_stall) && !mem_stall);

  assign exc_pc = (mem_excepttype == ERET_CODE) ? mem_cp0_epc : EXC_VECTOR;

  // The live exception wins over a held one so the latest target is always presented.
  always_comb begin
    mem_newpc = 32'd0;
    if (exc) begin
      mem_newpc = exc_pc;
    end else if (pend_q) begin
      mem_newpc = pend_pc_q;
    end
  end

  assign redirect_valid = flush_all;

  always_comb begin
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    if (exc && stallreq_from_if) begin
      pend_d    = 1'b1;
      pend_pc_d = exc_pc;
    end else if (!stallreq_from_if) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q    <= 1'b0;
      pend_pc_q <= 32'd0;
    end else begin
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs = '0, id_rt = '0, ex_rt = '0;
  logic        ex_rmem = 1'b0;
  logic        id_j_b_stall = 1'b0, stallreq_from_if = 1'b0, stallreq_from_mem = 1'b0;
  logic [1:0]  mc_req = '0, mc_ready = '0;
  logic [1:0]  mc_start, mc_abort;
  logic [31:0] mem_excepttype = '0, mem_cp0_epc = '0;
  logic        if_stall, id_stall, ex_stall, mem_stall, wb_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush, wb_flush;
  logic [31:0] mem_newpc;
  logic        redirect_valid;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] VEC = 32'hBFC00380;
  localparam logic [31:0] EPC = 32'h80001234;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt), .ex_rmem(ex_rmem),
    .id_j_b_stall(id_j_b_stall), .stallreq_from_if(stallreq_from_if),
    .stallreq_from_mem(stallreq_from_mem),
    .mc_req(mc_req), .mc_ready(mc_ready), .mc_start(mc_start), .mc_abort(mc_abort),
    .mem_excepttype(mem_excepttype), .mem_cp0_epc(mem_cp0_epc),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall),
    .mem_stall(mem_stall), .wb_stall(wb_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush),
    .mem_flush(mem_flush), .wb_flush(wb_flush),
    .mem_newpc(mem_newpc), .redirect_valid(redirect_valid)
  );

  always #5 clk = ~clk;

  logic [46:0] obs;
  assign obs = {mc_start, mc_abort,
                if_stall, id_stall, ex_stall, mem_stall, wb_stall,
                if_flush, id_flush, ex_flush, mem_flush, wb_flush,
                redirect_valid, mem_newpc};

  typedef struct {
    string       tag;
    logic [46:0] exp;
  } sb_t;
  sb_t sb_q[$];

  // stl / fl bit order: if, id, ex, mem, wb
  function automatic logic [46:0] ev(logic [1:0] st, logic [1:0] ab, logic [4:0] stl,
                                     logic [4:0] fl, logic rv, logic [31:0] pc);
    return {st, ab, stl, fl, rv, pc};
  endfunction

  task automatic push(input string tag, input logic [46:0] e);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sb_q.push_back(s);
  endtask

  task automatic check();
    sb_t s;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=%0d required=1", sb_q.size());
    end else begin
      s = sb_q.pop_front();
      total++;
      assert (obs === s.exp) else begin
        bad++;
        $error("FAIL %s observed=%h required=%h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [46:0] e);
    push(tag, e);
    @(negedge clk);
    check();
  endtask

  initial begin
    // reset state
    #2;
    step("reset", ev(2'b00, 2'b00, 5'b00000, 5'b00000, 1'b0, 32'd0));
    mem_excepttype = 32'h8;
    #1;
    push("reset_exc_pc", ev(2'b00, 2'b00, 5'b00000, 5'b11111, 1'b1, VEC));
    #1;
    check();
    mem_excepttype = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    step("idle", ev(2'b00, 2'b00, 5'b00000, 5'b00000, 1'b0, 32'd0));

    // load-use
    tick();
    ex_rmem = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    step("loaduse_rs", ev(2'b00, 2'b00, 5'b11000, 5'b00100, 1'b0, 32'd0));
    tick();
    ex_rt = 5'd0; id_rs = 5'd0;
    step("loaduse_r0", ev(2'b00, 2'b00, 5'b00000, 5'b00000, 1'b0, 32'd0));
    tick();
    ex_rt = 5'd7; id_rt = 5'd7;
    step("loaduse_rt", ev(2'b00, 2'b00, 5'b11000, 5'b00100, 1'b0, 32'd0));
    tick();
    ex_rmem = 1'b0;
    step("no_load", ev(2'b00, 2'b00, 5'b00000, 5'b00000, 1'b0, 32'd0));
    ex_rt = 5'd0; id_rt = 5'd0;

    // branch stall masked by mem stall, then if stall alone
    tick();
    id_j_b_stall = 1'b1; stallreq_from_mem = 1'b1;
    step("jb_memstall", ev(2'b00, 2'b00, 5'b11111, 5'b00000, 1'b0, 32'd0));
    tick();
    stallreq_from_mem = 1'b0;
    step("jb_only", ev(2'b00, 2'b00, 5'b11000, 5'b00100, 1'b0, 32'd0));
    tick();
    id_j_b_stall = 1'b0; stallreq_from_if = 1'b1;
    step("if_only", ev(2'b00, 2'b00, 5'b11000, 5'b00000, 1'b0, 32'd0));
    stallreq_from_if = 1'b0;

    // divide: 7 stall cycles then DONE
    tick();
    mc_req = 2'b10;
    step("div_c0", ev(2'b00, 2'b00, 5'b11111, 5'b00000, 1'b0, 32'd0));
    tick();
    step("div_start", ev(2'b10, 2'b00, 5'b11111, 5'b00000, 1'b0, 32'd0));
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (c == 6) mc_ready = 2'b10;
      step($sformatf("div_wait_c%0d", c), ev(2'b00, 2'b00, 5'b11111, 5'b00000, 1'b0, 32'd0));
    end
    tick();
    step("div_done", ev(2'b00, 2'b00, 5'b00000, 5'b00000, 1'b0, 32'd0));
    mc_req = 2'b00; mc_ready = 2'b00;
    tick();
    step("div_after", ev(2'b00, 2'b00, 5'b00000, 5'b00000, 1'b0, 32'd0));

    // exceptions
    tick();
    mem_excepttype = 32'h8;
    step("exc_vector", ev(2'b00, 2'b00, 5'b00000, 5'b11111, 1'b1, VEC));
    tick();
    mem_excepttype = 32'he; mem_cp0_epc = EPC;
    step("exc_eret", ev(2'b00, 2'b00, 5'b00000, 5'b11111, 1'b1, EPC));
    tick();
    mem_excepttype = 32'h0;
    step("exc_clear", ev(2'b00, 2'b00, 5'b00000, 5'b00000, 1'b0, 32'd0));

    // deferred redirect behind an IF stall
    tick();
    mem_excepttype = 32'h8; stallreq_from_if = 1'b1;
    step("pend_c0", ev(2'b00, 2'b00, 5'b11000, 5'b11111, 1'b1, VEC));
    tick();
    mem_excepttype = 32'h0;
    step("pend_c1", ev(2'b00, 2'b00, 5'b11000, 5'b11111, 1'b1, VEC));
    tick();
    step("pend_c2", ev(2'b00, 2'b00, 5'b11000, 5'b11111, 1'b1, VEC));
    tick();
    stallreq_from_if = 1'b0;
    step("pend_c3", ev(2'b00, 2'b00, 5'b00000, 5'b11111, 1'b1, VEC));
    tick();
    step("pend_gone", ev(2'b00, 2'b00, 5'b00000, 5'b00000, 1'b0, 32'd0));

    // latest exception overwrites the held target
    tick();
    mem_excepttype = 32'h8; stallreq_from_if = 1'b1;
    step("latest_a", ev(2'b00, 2'b00, 5'b11000, 5'b11111, 1'b1, VEC));
    tick();
    mem_excepttype = 32'he;
    step("latest_b", ev(2'b00, 2'b00, 5'b11000, 5'b11111, 1'b1, EPC));
    tick();
    mem_excepttype = 32'h0; stallreq_from_if = 1'b0;
    step("latest_held", ev(2'b00, 2'b00, 5'b00000, 5'b11111, 1'b1, EPC));
    tick();
    step("latest_gone", ev(2'b00, 2'b00, 5'b00000, 5'b00000, 1'b0, 32'd0));

    // exception during divide WAIT aborts; req with exc does not start
    tick();
    mc_req = 2'b10;
    step("abt_c0", ev(2'b00, 2'b00, 5'b11111, 5'b00000, 1'b0, 32'd0));
    tick();
    step("abt_start", ev(2'b10, 2'b00, 5'b11111, 5'b00000, 1'b0, 32'd0));
    tick();
    step("abt_wait", ev(2'b00, 2'b00, 5'b11111, 5'b00000, 1'b0, 32'd0));
    tick();
    mem_excepttype = 32'h8;
    step("abt_pulse", ev(2'b00, 2'b10, 5'b11111, 5'b11111, 1'b1, VEC));
    tick();
    step("abt_req_exc", ev(2'b00, 2'b00, 5'b11111, 5'b11111, 1'b1, VEC));
    tick();
    mem_excepttype = 32'h0; mc_req = 2'b00;
    step("abt_idle", ev(2'b00, 2'b00, 5'b00000, 5'b00000, 1'b0, 32'd0));
    tick();
    step("abt_norefire", ev(2'b00, 2'b00, 5'b00000, 5'b00000, 1'b0, 32'd0));

    // asynchronous reset mid-WAIT
    tick();
    mc_req = 2'b10;
    step("rst_c0", ev(2'b00, 2'b00, 5'b11111, 5'b00000, 1'b0, 32'd0));
    tick();
    step("rst_start", ev(2'b10, 2'b00, 5'b11111, 5'b00000, 1'b0, 32'd0));
    tick();
    step("rst_wait", ev(2'b00, 2'b00, 5'b11111, 5'b00000, 1'b0, 32'd0));
    #2;
    rst = 1'b1;
    #1;
    push("rst_async", ev(2'b00, 2'b00, 5'b00000, 5'b00000, 1'b0, 32'd0));
    check();
    tick();
    step("rst_held", ev(2'b00, 2'b00, 5'b00000, 5'b00000, 1'b0, 32'd0));
    rst = 1'b0; mc_req = 2'b00;
    tick();
    step("rst_release", ev(2'b00, 2'b00, 5'b00000, 5'b00000, 1'b0, 32'd0));

    if (sb_q.size() != 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d required=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
